// File: rtl/bus_pkg.sv
// Shared types and widths for the round-robin bus interconnect.
package bus_pkg;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index fields are sized for the largest supported configuration (8 hosts, 16 devices).
  localparam int HOST_IDX_W = idx_w(8);
  localparam int DEV_IDX_W  = idx_w(16);

  localparam logic [DEV_IDX_W-1:0] DEV_NONE = '1;

  typedef struct packed {
    logic                  vld;
    logic [HOST_IDX_W-1:0] host_idx;
    logic [DEV_IDX_W-1:0]  dev_idx;
    logic                  miss;
  } rsp_t;

endpackage

// File: rtl/bus_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after the pointer wins.
module bus_rr_arbiter
  import bus_pkg::*;
#(
  parameter int NR_HOSTS = 2
) (
  input  logic [NR_HOSTS-1:0]   i_req,
  input  logic [HOST_IDX_W-1:0] i_ptr,
  output logic [NR_HOSTS-1:0]   o_gnt,
  output logic                  o_vld,
  output logic [HOST_IDX_W-1:0] o_idx,
  output logic [HOST_IDX_W-1:0] o_nxt_ptr
);

  always_comb begin
    o_gnt     = '0;
    o_vld     = 1'b0;
    o_idx     = '0;
    o_nxt_ptr = i_ptr;
    for (int o = 0; o < NR_HOSTS; o++) begin
      for (int k = 0; k < NR_HOSTS; k++) begin
        if (!o_vld && i_req[k] && (((int'(i_ptr) + o) % NR_HOSTS) == k)) begin
          o_vld     = 1'b1;
          o_gnt[k]  = 1'b1;
          o_idx     = HOST_IDX_W'(k);
          o_nxt_ptr = HOST_IDX_W'((k + 1) % NR_HOSTS);
        end
      end
    end
  end

endmodule

// File: rtl/bus_rr_xbar.sv
// N-host to M-device single-outstanding bus interconnect with base/mask decode.
// Optional feature macro: BUS_ERR_EN (report no-match accesses on host_err_o).
module bus_rr_xbar
  import bus_pkg::*;
#(
  parameter int NR_HOSTS   = 2,
  parameter int NR_DEVICES = 5,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NR_HOSTS-1:0]              host_req_i,
  output logic [NR_HOSTS-1:0]              host_gnt_o,
  input  logic [NR_HOSTS*ADDR_WIDTH-1:0]   host_addr_i,
  input  logic [NR_HOSTS-1:0]              host_we_i,
  input  logic [NR_HOSTS*DATA_WIDTH-1:0]   host_wdata_i,
  output logic [NR_HOSTS-1:0]              host_rvalid_o,
  output logic [NR_HOSTS*DATA_WIDTH-1:0]   host_rdata_o,
  output logic [NR_HOSTS-1:0]              host_err_o,
  output logic [NR_DEVICES-1:0]            dev_req_o,
  output logic [ADDR_WIDTH-1:0]            dev_addr_o,
  output logic                             dev_we_o,
  output logic [DATA_WIDTH-1:0]            dev_wdata_o,
  input  logic [NR_DEVICES*DATA_WIDTH-1:0] dev_rdata_i,
  input  logic [NR_DEVICES*ADDR_WIDTH-1:0] cfg_dev_base_i,
  input  logic [NR_DEVICES*ADDR_WIDTH-1:0] cfg_dev_mask_i
);

  logic [HOST_IDX_W-1:0] r_ptr;
  rsp_t                  r_rsp;

  logic [NR_HOSTS-1:0]   w_req;
  logic [NR_HOSTS-1:0]   w_gnt;
  logic                  w_gnt_vld;
  logic [HOST_IDX_W-1:0] w_gnt_idx;
  logic [HOST_IDX_W-1:0] w_nxt_ptr;
  logic                  w_hit;
  logic [DEV_IDX_W-1:0]  w_dev_idx;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Requests are masked while reset is held so no grant escapes combinationally.
  assign w_req = host_req_i & {NR_HOSTS{rst_ni}};

  bus_rr_arbiter #(
    .NR_HOSTS (NR_HOSTS)
  ) u_arb (
    .i_req     (w_req),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_vld     (w_gnt_vld),
    .o_idx     (w_gnt_idx),
    .o_nxt_ptr (w_nxt_ptr)
  );

  assign host_gnt_o = w_gnt;

  always_comb begin
    dev_addr_o  = '0;
    dev_we_o    = 1'b0;
    dev_wdata_o = '0;
    for (int k = 0; k < NR_HOSTS; k++) begin
      if (w_gnt[k]) begin
        dev_addr_o  = host_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        dev_we_o    = host_we_i[k];
        dev_wdata_o = host_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Descending scan so the lowest matching window has the final say.
  always_comb begin
    w_hit     = 1'b0;
    w_dev_idx = DEV_NONE;
    for (int d = NR_DEVICES - 1; d >= 0; d--) begin
      if ((dev_addr_o & cfg_dev_mask_i[d*ADDR_WIDTH +: ADDR_WIDTH]) ==
          cfg_dev_base_i[d*ADDR_WIDTH +: ADDR_WIDTH]) begin
        w_hit     = 1'b1;
        w_dev_idx = DEV_IDX_W'(d);
      end
    end
  end

  always_comb begin
    dev_req_o = '0;
    for (int d = 0; d < NR_DEVICES; d++) begin
      dev_req_o[d] = w_gnt_vld && w_hit && (w_dev_idx == DEV_IDX_W'(d));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
      r_rsp <= '{vld: 1'b0, host_idx: '0, dev_idx: DEV_NONE, miss: 1'b0};
    end else begin
      if (w_gnt_vld) begin
        r_ptr <= w_nxt_ptr;
      end
      r_rsp.vld      <= w_gnt_vld;
      r_rsp.host_idx <= w_gnt_idx;
      r_rsp.dev_idx  <= w_hit ? w_dev_idx : DEV_NONE;
      r_rsp.miss     <= w_gnt_vld && !w_hit;
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int d = 0; d < NR_DEVICES; d++) begin
      if (!r_rsp.miss && (r_rsp.dev_idx == DEV_IDX_W'(d))) begin
        w_rdata = dev_rdata_i[d*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    host_rvalid_o = '0;
    host_rdata_o  = '0;
    host_err_o    = '0;
    for (int k = 0; k < NR_HOSTS; k++) begin
      if (r_rsp.vld && (r_rsp.host_idx == HOST_IDX_W'(k))) begin
        host_rvalid_o[k]                      = 1'b1;
        host_rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = w_rdata;
`ifdef BUS_ERR_EN
        host_err_o[k]                         = r_rsp.miss;
`else
        host_err_o[k]                         = 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_bus_rr_xbar.sv
// Directed, table-driven bench for bus_rr_xbar (2 hosts, 5 devices).
module tb_bus_rr_xbar;

  localparam int AW = 32;
  localparam int DW = 32;

`ifdef BUS_ERR_EN
  localparam logic EE = 1'b1;
`else
  localparam logic EE = 1'b0;
`endif

  localparam logic [31:0] A_RAM = 32'h0000_0100;
  localparam logic [31:0] A_CLI = 32'h0200_0000;
  localparam logic [31:0] A_CON = 32'h0020_0000;
  localparam logic [31:0] A_D3  = 32'h0030_0000;
  localparam logic [31:0] A_D4  = 32'h0031_0000;
  localparam logic [31:0] A_NM  = 32'h0400_0000;
  localparam logic [31:0] D_RAM = 32'h1234_5678;
  localparam logic [31:0] D_CLI = 32'hC11E_0001;
  localparam logic [31:0] D_CON = 32'hC0C0_0002;
  localparam logic [31:0] D_D3  = 32'h3333_3333;
  localparam logic [31:0] D_D4  = 32'h4444_4444;
  localparam logic [31:0] WD0   = 32'h0000_00A5;
  localparam logic [31:0] WD1   = 32'h0000_005A;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic [1:0]     host_req_i;
  logic [1:0]     host_gnt_o;
  logic [2*AW-1:0] host_addr_i;
  logic [1:0]     host_we_i;
  logic [2*DW-1:0] host_wdata_i;
  logic [1:0]     host_rvalid_o;
  logic [2*DW-1:0] host_rdata_o;
  logic [1:0]     host_err_o;
  logic [4:0]     dev_req_o;
  logic [AW-1:0]  dev_addr_o;
  logic           dev_we_o;
  logic [DW-1:0]  dev_wdata_o;
  logic [5*DW-1:0] dev_rdata_i;
  logic [5*AW-1:0] cfg_dev_base_i;
  logic [5*AW-1:0] cfg_dev_mask_i;

  always #5 clk_i = ~clk_i;

  bus_rr_xbar #(
    .NR_HOSTS   (2),
    .NR_DEVICES (5),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .host_req_i     (host_req_i),
    .host_gnt_o     (host_gnt_o),
    .host_addr_i    (host_addr_i),
    .host_we_i      (host_we_i),
    .host_wdata_i   (host_wdata_i),
    .host_rvalid_o  (host_rvalid_o),
    .host_rdata_o   (host_rdata_o),
    .host_err_o     (host_err_o),
    .dev_req_o      (dev_req_o),
    .dev_addr_o     (dev_addr_o),
    .dev_we_o       (dev_we_o),
    .dev_wdata_o    (dev_wdata_o),
    .dev_rdata_i    (dev_rdata_i),
    .cfg_dev_base_i (cfg_dev_base_i),
    .cfg_dev_mask_i (cfg_dev_mask_i)
  );

  typedef struct {
    logic [1:0]  req;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [1:0]  we;
    logic [1:0]  gnt;
    logic [4:0]  dreq;
    logic        dwe;
    logic [31:0] dwd;
    logic [1:0]  rv;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [1:0]  chk;
    logic [1:0]  err;
  } vec_t;

  vec_t vecs[16];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(logic [1:0] req, logic [31:0] a0, logic [31:0] a1, logic [1:0] we,
                              logic [1:0] gnt, logic [4:0] dreq, logic dwe, logic [31:0] dwd,
                              logic [1:0] rv, logic [31:0] rd0, logic [31:0] rd1,
                              logic [1:0] chk, logic [1:0] err);
    vec_t v;
    v.req = req; v.a0 = a0; v.a1 = a1; v.we = we; v.gnt = gnt; v.dreq = dreq;
    v.dwe = dwe; v.dwd = dwd; v.rv = rv; v.rd0 = rd0; v.rd1 = rd1; v.chk = chk; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    dev_rdata_i    = {D_D4, D_D3, D_CON, D_CLI, D_RAM};
    cfg_dev_base_i = {A_D4, A_D3, A_CON, 32'h0200_0000, 32'h0000_0000};
    cfg_dev_mask_i = {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFF0_0000};
    host_wdata_i   = {WD1, WD0};
    host_we_i      = 2'b00;
    host_addr_i    = {A_RAM, A_RAM};

    //            req    a0     a1     we     gnt    dreq      dwe   dwd  rv     rd0    rd1    chk    err
    vecs[0]  = mk(2'b11, A_RAM, A_RAM, 2'b00, 2'b01, 5'b00001, 1'b0, 0,   2'b00, 0,     0,     2'b11, 2'b00);
    vecs[1]  = mk(2'b11, A_RAM, A_RAM, 2'b00, 2'b10, 5'b00001, 1'b0, 0,   2'b01, D_RAM, 0,     2'b11, 2'b00);
    vecs[2]  = mk(2'b11, A_RAM, A_RAM, 2'b00, 2'b01, 5'b00001, 1'b0, 0,   2'b10, 0,     D_RAM, 2'b11, 2'b00);
    vecs[3]  = mk(2'b11, A_RAM, A_RAM, 2'b00, 2'b10, 5'b00001, 1'b0, 0,   2'b01, D_RAM, 0,     2'b11, 2'b00);
    vecs[4]  = mk(2'b11, A_RAM, A_RAM, 2'b00, 2'b01, 5'b00001, 1'b0, 0,   2'b10, 0,     D_RAM, 2'b11, 2'b00);
    vecs[5]  = mk(2'b11, A_RAM, A_RAM, 2'b00, 2'b10, 5'b00001, 1'b0, 0,   2'b01, D_RAM, 0,     2'b11, 2'b00);
    vecs[6]  = mk(2'b00, A_RAM, A_RAM, 2'b00, 2'b00, 5'b00000, 1'b0, 0,   2'b10, 0,     D_RAM, 2'b11, 2'b00);
    vecs[7]  = mk(2'b01, A_D3,  A_RAM, 2'b01, 2'b01, 5'b01000, 1'b1, WD0, 2'b00, 0,     0,     2'b11, 2'b00);
    vecs[8]  = mk(2'b01, A_D4,  A_RAM, 2'b01, 2'b01, 5'b10000, 1'b1, WD0, 2'b01, 0,     0,     2'b10, 2'b00);
    vecs[9]  = mk(2'b01, A_NM,  A_RAM, 2'b00, 2'b01, 5'b00000, 1'b0, 0,   2'b01, 0,     0,     2'b10, 2'b00);
    vecs[10] = mk(2'b00, A_NM,  A_RAM, 2'b00, 2'b00, 5'b00000, 1'b0, 0,   2'b01, 0,     0,     2'b11, {1'b0, EE});
    vecs[11] = mk(2'b10, A_NM,  A_CLI, 2'b00, 2'b10, 5'b00010, 1'b0, 0,   2'b00, 0,     0,     2'b11, 2'b00);
    vecs[12] = mk(2'b01, A_CON, A_CLI, 2'b01, 2'b01, 5'b00100, 1'b1, WD0, 2'b10, 0,     D_CLI, 2'b11, 2'b00);
    vecs[13] = mk(2'b00, A_CON, A_CLI, 2'b00, 2'b00, 5'b00000, 1'b0, 0,   2'b01, 0,     0,     2'b10, 2'b00);
    vecs[14] = mk(2'b10, A_CON, A_NM,  2'b10, 2'b10, 5'b00000, 1'b1, WD1, 2'b00, 0,     0,     2'b11, 2'b00);
    vecs[15] = mk(2'b00, A_CON, A_NM,  2'b00, 2'b00, 5'b00000, 1'b0, 0,   2'b10, 0,     0,     2'b01, {EE, 1'b0});

    // Reset held with both hosts requesting: nothing may be granted or issued.
    rst_ni     = 1'b0;
    host_req_i = 2'b11;
    repeat (2) @(negedge clk_i);
    chk("reset gnt", 32'(host_gnt_o), 32'h0);
    chk("reset rvalid", 32'(host_rvalid_o), 32'h0);
    chk("reset dev_req", 32'(dev_req_o), 32'h0);
    chk("reset err", 32'(host_err_o), 32'h0);
    chk("reset rdata", host_rdata_o[31:0] | host_rdata_o[63:32], 32'h0);
    host_req_i = 2'b00;
    rst_ni     = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(posedge clk_i);
      #1;
      host_req_i  = vecs[i].req;
      host_addr_i = {vecs[i].a1, vecs[i].a0};
      host_we_i   = vecs[i].we;
      @(negedge clk_i);
      chk($sformatf("v%0d gnt", i), 32'(host_gnt_o), 32'(vecs[i].gnt));
      chk($sformatf("v%0d dev_req", i), 32'(dev_req_o), 32'(vecs[i].dreq));
      chk($sformatf("v%0d dev_we", i), 32'(dev_we_o), 32'(vecs[i].dwe));
      if (vecs[i].dwe) chk($sformatf("v%0d dev_wdata", i), dev_wdata_o, vecs[i].dwd);
      chk($sformatf("v%0d rvalid", i), 32'(host_rvalid_o), 32'(vecs[i].rv));
      if (vecs[i].chk[0]) chk($sformatf("v%0d rdata0", i), host_rdata_o[31:0], vecs[i].rd0);
      if (vecs[i].chk[1]) chk($sformatf("v%0d rdata1", i), host_rdata_o[63:32], vecs[i].rd1);
      chk($sformatf("v%0d err", i), 32'(host_err_o), 32'(vecs[i].err));
    end

    // Reset one cycle after a grant to host0: the response is dropped and the pointer returns to 0.
    @(posedge clk_i);
    #1;
    host_req_i  = 2'b01;
    host_addr_i = {A_RAM, A_RAM};
    host_we_i   = 2'b00;
    @(negedge clk_i);
    chk("mid-reset grant", 32'(host_gnt_o), 32'h1);
    @(posedge clk_i);
    #1;
    host_req_i = 2'b00;
    rst_ni     = 1'b0;
    @(negedge clk_i);
    chk("mid-reset rvalid", 32'(host_rvalid_o), 32'h0);
    chk("mid-reset rdata0", host_rdata_o[31:0], 32'h0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post-reset rvalid", 32'(host_rvalid_o), 32'h0);
    @(posedge clk_i);
    #1;
    host_req_i = 2'b11;
    @(negedge clk_i);
    chk("post-reset ptr", 32'(host_gnt_o), 32'h1);
    @(posedge clk_i);
    #1;
    host_req_i = 2'b00;
    @(negedge clk_i);
    chk("post-reset rvalid0", 32'(host_rvalid_o), 32'h1);
    chk("post-reset rdata0", host_rdata_o[31:0], D_RAM);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
